// File: rtl/keypad_link_if.sv
// Status/key link bundle between the alarm controller side and the keypad.
//   STATUS_SEND/STATUS_OUT : serial status frames from the controller
//   BTN_IN                 : raw digit buttons (one bit per digit)
//   KB_IN/KB_RECV          : key code and one-cycle strobe toward the controller
//   STATUS_MSG/MSG_VALID   : last valid status frame and its update pulse
//   FRAME_ERR              : one-cycle pulse on an aborted frame
//   LINK_LOST              : status-frame watchdog flag
// master = controller/environment side, slave = keypad_link.
interface keypad_link_if #(
  parameter int unsigned MSG_BITS = 4
);
  logic                STATUS_SEND;
  logic                STATUS_OUT;
  logic [3:0]          BTN_IN;
  logic [1:0]          KB_IN;
  logic                KB_RECV;
  logic [MSG_BITS-1:0] STATUS_MSG;
  logic                MSG_VALID;
  logic                FRAME_ERR;
  logic                LINK_LOST;

  modport master (
    output STATUS_SEND, STATUS_OUT, BTN_IN,
    input  KB_IN, KB_RECV, STATUS_MSG, MSG_VALID, FRAME_ERR, LINK_LOST
  );

  modport slave (
    input  STATUS_SEND, STATUS_OUT, BTN_IN,
    output KB_IN, KB_RECV, STATUS_MSG, MSG_VALID, FRAME_ERR, LINK_LOST
  );
endinterface

// File: rtl/keypad_link.sv
// Keypad-side endpoint of the alarm controller status/key link.
// - Rx: deserializes marker-started, MSB-first status frames into STATUS_MSG,
//   pulsing MSG_VALID on load and FRAME_ERR when a marker interrupts a frame.
// - Watchdog: LINK_LOST rises after LINK_TIMEOUT cycles without a valid frame.
// - Tx: debounces one-hot digit presses into single KB_RECV/KB_IN transfers,
//   then waits for a debounced release (no auto-repeat).
// Ports: CLK, RST (synchronous, active-high), bus (keypad_link_if.slave).
module keypad_link #(
  parameter int unsigned MSG_BITS     = 4,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned LINK_TIMEOUT = 64
) (
  input logic          CLK,
  input logic          RST,
  keypad_link_if.slave bus
);

  localparam int unsigned BIT_W = (MSG_BITS > 1) ? $clog2(MSG_BITS) : 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
  localparam int unsigned WD_W  = $clog2(LINK_TIMEOUT + 1);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(MSG_BITS - 1);
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(LINK_TIMEOUT);

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_WAIT_PRESS,
    TX_EMIT,
    TX_WAIT_RELEASE
  } tx_state_e;

  // Rx / watchdog state
  rx_state_e            rx_state_q, rx_state_d;
  logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [MSG_BITS-1:0]  shift_q, shift_d;
  logic [MSG_BITS-1:0]  msg_q, msg_d;
  logic                 msg_valid_q, msg_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 lost_q, lost_d;

  // Tx state
  tx_state_e            tx_state_q, tx_state_d;
  logic [DB_W-1:0]      db_q, db_d;
  logic [3:0]           cand_q, cand_d;
  logic [1:0]           kb_in_q, kb_in_d;
  logic                 kb_recv_q, kb_recv_d;

  logic                 btn_onehot;
  logic [DB_W-1:0]      press_run;
  logic [1:0]           btn_idx;

  // ---------------------------------------------------------------- Rx path
  always_comb begin
    rx_state_d  = rx_state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    msg_d       = msg_q;
    msg_valid_d = 1'b0;
    frame_err_d = 1'b0;

    unique case (rx_state_q)
      RX_IDLE: begin
        if (bus.STATUS_SEND) begin
          rx_state_d = RX_SHIFT;
          bitcnt_d   = '0;
        end
      end
      RX_SHIFT: begin
        if (bus.STATUS_SEND) begin
          // A marker mid-frame discards the partial frame and starts a new one.
          frame_err_d = 1'b1;
          bitcnt_d    = '0;
        end else begin
          shift_d = MSG_BITS'({shift_q, bus.STATUS_OUT});
          if (bitcnt_q == LAST_BIT) begin
            msg_d       = shift_d;
            msg_valid_d = 1'b1;
            rx_state_d  = RX_IDLE;
            bitcnt_d    = '0;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Watchdog: cleared on the same edge that loads a frame, saturating count.
  always_comb begin
    wd_d = wd_q;
    if (msg_valid_d) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 1'b1;
    end
    lost_d = msg_valid_d ? 1'b0 : (lost_q | (wd_d == WD_MAX));
  end

  // ---------------------------------------------------------------- Tx path
  always_comb begin
    btn_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bus.BTN_IN[i]) btn_idx = 2'(i);
    end
  end

  assign btn_onehot = $onehot(bus.BTN_IN);
  // Length of the run of identical samples including the current one.
  assign press_run  = (bus.BTN_IN == cand_q) ? db_q + 1'b1 : DB_W'(1);

  always_comb begin
    tx_state_d = tx_state_q;
    db_d       = db_q;
    cand_d     = cand_q;
    kb_in_d    = kb_in_q;
    kb_recv_d  = 1'b0;

    unique case (tx_state_q)
      TX_WAIT_PRESS: begin
        cand_d = bus.BTN_IN;
        if (!btn_onehot) begin
          db_d = '0;
        end else if (press_run == DB_MAX) begin
          tx_state_d = TX_EMIT;
          kb_recv_d  = 1'b1;
          kb_in_d    = btn_idx;
          db_d       = '0;
        end else begin
          db_d = press_run;
        end
      end
      TX_EMIT: begin
        tx_state_d = TX_WAIT_RELEASE;
        db_d       = '0;
      end
      TX_WAIT_RELEASE: begin
        cand_d = '0;
        if (bus.BTN_IN != '0) begin
          db_d = '0;
        end else if ((db_q + 1'b1) == DB_MAX) begin
          tx_state_d = TX_WAIT_PRESS;
          db_d       = '0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = TX_WAIT_PRESS;
        db_d       = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------- State
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_state_q  <= RX_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      msg_q       <= '0;
      msg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      wd_q        <= '0;
      lost_q      <= 1'b1;
      tx_state_q  <= TX_WAIT_PRESS;
      db_q        <= '0;
      cand_q      <= '0;
      kb_in_q     <= '0;
      kb_recv_q   <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      msg_q       <= msg_d;
      msg_valid_q <= msg_valid_d;
      frame_err_q <= frame_err_d;
      wd_q        <= wd_d;
      lost_q      <= lost_d;
      tx_state_q  <= tx_state_d;
      db_q        <= db_d;
      cand_q      <= cand_d;
      kb_in_q     <= kb_in_d;
      kb_recv_q   <= kb_recv_d;
    end
  end

  assign bus.STATUS_MSG = msg_q;
  assign bus.MSG_VALID  = msg_valid_q;
  assign bus.FRAME_ERR  = frame_err_q;
  assign bus.LINK_LOST  = lost_q;
  assign bus.KB_IN      = kb_in_q;
  assign bus.KB_RECV    = kb_recv_q;

endmodule

// File: tb/tb_keypad_link.sv
// Directed self-checking bench for keypad_link (MSG_BITS=4, DEBOUNCE=4,
// LINK_TIMEOUT=64). Inputs change 1 ns after each rising edge; outputs are
// sampled at the same point, so each sample shows the registered values of
// the cycle that edge opened.
module tb_keypad_link;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  keypad_link_if #(.MSG_BITS(4)) bus ();

  keypad_link #(
    .MSG_BITS    (4),
    .DEBOUNCE    (4),
    .LINK_TIMEOUT(64)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.STATUS_SEND = 1'b0; bus.STATUS_OUT = 1'b0; bus.BTN_IN = 4'b0000;
    tick(); tick();
    checks++; if (bus.KB_IN !== 2'd0) begin errors++; $display("FAIL rst_kb_in got %0d exp 0", bus.KB_IN); end
    checks++; if (bus.KB_RECV !== 1'b0) begin errors++; $display("FAIL rst_kb_recv got %b exp 0", bus.KB_RECV); end
    checks++; if (bus.STATUS_MSG !== 4'b0000) begin errors++; $display("FAIL rst_msg got %b exp 0000", bus.STATUS_MSG); end
    checks++; if (bus.MSG_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.MSG_VALID); end
    checks++; if (bus.FRAME_ERR !== 1'b0) begin errors++; $display("FAIL rst_ferr got %b exp 0", bus.FRAME_ERR); end
    checks++; if (bus.LINK_LOST !== 1'b1) begin errors++; $display("FAIL rst_lost got %b exp 1", bus.LINK_LOST); end
    RST = 1'b0;
  endtask

  task automatic test_frame();
    logic [3:0] pay;
    pay = 4'b1101;
    bus.STATUS_SEND = 1'b1; tick();
    bus.STATUS_SEND = 1'b0;
    checks++; if (bus.LINK_LOST !== 1'b1) begin errors++; $display("FAIL frame_lost_before got %b exp 1", bus.LINK_LOST); end
    for (int i = 3; i >= 0; i--) begin
      checks++; if (bus.MSG_VALID !== 1'b0) begin errors++; $display("FAIL frame_early_valid bit %0d got %b exp 0", i, bus.MSG_VALID); end
      bus.STATUS_OUT = pay[i];
      tick();
    end
    bus.STATUS_OUT = 1'b0;
    checks++; if (bus.MSG_VALID !== 1'b1) begin errors++; $display("FAIL frame_valid got %b exp 1", bus.MSG_VALID); end
    checks++; if (bus.STATUS_MSG !== 4'b1101) begin errors++; $display("FAIL frame_msg got %b exp 1101", bus.STATUS_MSG); end
    checks++; if (bus.LINK_LOST !== 1'b0) begin errors++; $display("FAIL frame_lost_after got %b exp 0", bus.LINK_LOST); end
    tick();
    checks++; if (bus.MSG_VALID !== 1'b0) begin errors++; $display("FAIL frame_valid_width got %b exp 0", bus.MSG_VALID); end
    checks++; if (bus.STATUS_MSG !== 4'b1101) begin errors++; $display("FAIL frame_msg_hold got %b exp 1101", bus.STATUS_MSG); end
  endtask

  task automatic test_abort();
    logic [3:0] pay;
    int ferr;
    pay  = 4'b0100;
    ferr = 0;
    bus.STATUS_SEND = 1'b1; tick(); ferr += int'(bus.FRAME_ERR);
    bus.STATUS_SEND = 1'b0; bus.STATUS_OUT = 1'b1; tick(); ferr += int'(bus.FRAME_ERR);
    bus.STATUS_OUT = 1'b0; tick(); ferr += int'(bus.FRAME_ERR);
    bus.STATUS_SEND = 1'b1; tick();
    bus.STATUS_SEND = 1'b0;
    checks++; if (bus.FRAME_ERR !== 1'b1) begin errors++; $display("FAIL abort_ferr got %b exp 1", bus.FRAME_ERR); end
    for (int i = 3; i >= 0; i--) begin
      ferr += int'(bus.FRAME_ERR);
      checks++; if (bus.MSG_VALID !== 1'b0) begin errors++; $display("FAIL abort_early_valid bit %0d got %b exp 0", i, bus.MSG_VALID); end
      checks++; if (bus.STATUS_MSG !== 4'b1101) begin errors++; $display("FAIL abort_msg_kept bit %0d got %b exp 1101", i, bus.STATUS_MSG); end
      bus.STATUS_OUT = pay[i];
      tick();
    end
    bus.STATUS_OUT = 1'b0;
    ferr += int'(bus.FRAME_ERR);
    checks++; if (ferr != 1) begin errors++; $display("FAIL abort_ferr_count got %0d exp 1", ferr); end
    checks++; if (bus.MSG_VALID !== 1'b1) begin errors++; $display("FAIL abort_valid got %b exp 1", bus.MSG_VALID); end
    checks++; if (bus.STATUS_MSG !== 4'b0100) begin errors++; $display("FAIL abort_msg got %b exp 0100", bus.STATUS_MSG); end
  endtask

  // Entered in the MSG_VALID cycle of the previous frame (count = 0).
  task automatic test_watchdog();
    logic [3:0] pay;
    pay = 4'b0110;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 63) begin
        checks++; if (bus.LINK_LOST !== 1'b0) begin errors++; $display("FAIL wd_lost_63 got %b exp 0", bus.LINK_LOST); end
      end
      if (k == 64) begin
        checks++; if (bus.LINK_LOST !== 1'b1) begin errors++; $display("FAIL wd_lost_64 got %b exp 1", bus.LINK_LOST); end
      end
    end
    checks++; if (bus.LINK_LOST !== 1'b1) begin errors++; $display("FAIL wd_lost_sticky got %b exp 1", bus.LINK_LOST); end
    bus.STATUS_SEND = 1'b1; tick();
    bus.STATUS_SEND = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      bus.STATUS_OUT = pay[i];
      tick();
    end
    bus.STATUS_OUT = 1'b0;
    checks++; if (bus.MSG_VALID !== 1'b1) begin errors++; $display("FAIL wd_frame_valid got %b exp 1", bus.MSG_VALID); end
    checks++; if (bus.LINK_LOST !== 1'b0) begin errors++; $display("FAIL wd_lost_clear got %b exp 0", bus.LINK_LOST); end
    checks++; if (bus.STATUS_MSG !== 4'b0110) begin errors++; $display("FAIL wd_msg got %b exp 0110", bus.STATUS_MSG); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] a;
    logic [3:0] b;
    a = 4'b1010;
    b = 4'b0011;
    for (int i = 0; i <= 10; i++) begin
      checks++; if (bus.MSG_VALID !== (i == 5 || i == 10)) begin errors++; $display("FAIL b2b_valid cycle %0d got %b exp %b", i, bus.MSG_VALID, (i == 5 || i == 10)); end
      if (i == 5) begin
        checks++; if (bus.STATUS_MSG !== a) begin errors++; $display("FAIL b2b_msg_a got %b exp %b", bus.STATUS_MSG, a); end
      end
      if (i == 10) begin
        checks++; if (bus.STATUS_MSG !== b) begin errors++; $display("FAIL b2b_msg_b got %b exp %b", bus.STATUS_MSG, b); end
      end
      if (i == 0 || i == 5) begin
        bus.STATUS_SEND = 1'b1; bus.STATUS_OUT = 1'b0;
      end else if (i < 5) begin
        bus.STATUS_SEND = 1'b0; bus.STATUS_OUT = a[4-i];
      end else if (i < 10) begin
        bus.STATUS_SEND = 1'b0; bus.STATUS_OUT = b[9-i];
      end else begin
        bus.STATUS_SEND = 1'b0; bus.STATUS_OUT = 1'b0;
      end
      tick();
    end
    checks++; if (bus.FRAME_ERR !== 1'b0) begin errors++; $display("FAIL b2b_ferr got %b exp 0", bus.FRAME_ERR); end
  endtask

  task automatic test_key();
    int pulses;
    pulses = 0;
    bus.BTN_IN = 4'b0100;
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) bus.BTN_IN = 4'b0000;
      tick();
      pulses += int'(bus.KB_RECV);
      checks++; if (bus.KB_RECV !== (k == 4)) begin errors++; $display("FAIL key2_recv t+%0d got %b exp %b", k, bus.KB_RECV, (k == 4)); end
      if (k == 4) begin
        checks++; if (bus.KB_IN !== 2'd2) begin errors++; $display("FAIL key2_code got %0d exp 2", bus.KB_IN); end
      end
    end
    // Button low since cycle t+9? No: held through t+9, low from t+10.
    for (int k = 1; k <= 4; k++) begin
      tick();
      pulses += int'(bus.KB_RECV);
    end
    bus.BTN_IN = 4'b0010;
    for (int k = 1; k <= 6; k++) begin
      tick();
      pulses += int'(bus.KB_RECV);
      if (k == 3) begin
        checks++; if (bus.KB_IN !== 2'd2) begin errors++; $display("FAIL key_hold_code got %0d exp 2", bus.KB_IN); end
      end
      if (k == 4) begin
        checks++; if (bus.KB_RECV !== 1'b1) begin errors++; $display("FAIL key1_recv got %b exp 1", bus.KB_RECV); end
        checks++; if (bus.KB_IN !== 2'd1) begin errors++; $display("FAIL key1_code got %0d exp 1", bus.KB_IN); end
      end
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL key_pulse_count got %0d exp 2", pulses); end
    bus.BTN_IN = 4'b0000;
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_debounce();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 24; k++) begin
      bus.BTN_IN = ((k / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
      tick();
      pulses += int'(bus.KB_RECV);
    end
    bus.BTN_IN = 4'b0000;
    for (int k = 0; k < 6; k++) begin tick(); pulses += int'(bus.KB_RECV); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL db_toggle_pulses got %0d exp 0", pulses); end
    pulses = 0;
    bus.BTN_IN = 4'b0011;
    for (int k = 0; k < 20; k++) begin tick(); pulses += int'(bus.KB_RECV); end
    bus.BTN_IN = 4'b0000;
    for (int k = 0; k < 6; k++) begin tick(); pulses += int'(bus.KB_RECV); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL db_multi_pulses got %0d exp 0", pulses); end
    pulses = 0;
    bus.BTN_IN = 4'b0001;
    for (int k = 0; k < 3; k++) begin tick(); pulses += int'(bus.KB_RECV); end
    bus.BTN_IN = 4'b0000;
    for (int k = 0; k < 8; k++) begin tick(); pulses += int'(bus.KB_RECV); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL db_short_pulses got %0d exp 0", pulses); end
  endtask

  task automatic test_concurrent();
    logic [3:0] pay;
    pay = 4'b1001;
    for (int i = 0; i <= 6; i++) begin
      checks++; if (bus.MSG_VALID !== (i == 5)) begin errors++; $display("FAIL conc_valid cycle %0d got %b exp %b", i, bus.MSG_VALID, (i == 5)); end
      checks++; if (bus.KB_RECV !== (i == 5)) begin errors++; $display("FAIL conc_recv cycle %0d got %b exp %b", i, bus.KB_RECV, (i == 5)); end
      if (i == 5) begin
        checks++; if (bus.KB_IN !== 2'd3) begin errors++; $display("FAIL conc_code got %0d exp 3", bus.KB_IN); end
        checks++; if (bus.STATUS_MSG !== pay) begin errors++; $display("FAIL conc_msg got %b exp %b", bus.STATUS_MSG, pay); end
      end
      bus.STATUS_SEND = (i == 0);
      bus.STATUS_OUT  = (i >= 1 && i <= 4) ? pay[4-i] : 1'b0;
      bus.BTN_IN      = (i >= 1) ? 4'b1000 : 4'b0000;
      tick();
    end
    bus.BTN_IN = 4'b0000;
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_mid_reset();
    int pulses;
    pulses = 0;
    bus.STATUS_SEND = 1'b1; tick();
    bus.STATUS_SEND = 1'b0; bus.STATUS_OUT = 1'b1; bus.BTN_IN = 4'b0001; tick();
    bus.STATUS_OUT = 1'b0; tick();
    bus.STATUS_OUT = 1'b1; RST = 1'b1; bus.BTN_IN = 4'b0000; tick();
    RST = 1'b0;
    checks++; if (bus.KB_IN !== 2'd0) begin errors++; $display("FAIL mrst_kb_in got %0d exp 0", bus.KB_IN); end
    checks++; if (bus.KB_RECV !== 1'b0) begin errors++; $display("FAIL mrst_kb_recv got %b exp 0", bus.KB_RECV); end
    checks++; if (bus.STATUS_MSG !== 4'b0000) begin errors++; $display("FAIL mrst_msg got %b exp 0000", bus.STATUS_MSG); end
    checks++; if (bus.MSG_VALID !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b exp 0", bus.MSG_VALID); end
    checks++; if (bus.FRAME_ERR !== 1'b0) begin errors++; $display("FAIL mrst_ferr got %b exp 0", bus.FRAME_ERR); end
    checks++; if (bus.LINK_LOST !== 1'b1) begin errors++; $display("FAIL mrst_lost got %b exp 1", bus.LINK_LOST); end
    tick();
    bus.STATUS_OUT = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      pulses += int'(bus.MSG_VALID) + int'(bus.KB_RECV) + int'(bus.FRAME_ERR);
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL mrst_no_pulses got %0d exp 0", pulses); end
    checks++; if (bus.STATUS_MSG !== 4'b0000) begin errors++; $display("FAIL mrst_msg_after got %b exp 0000", bus.STATUS_MSG); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_frame();
    test_abort();
    test_watchdog();
    test_back_to_back();
    test_key();
    test_debounce();
    test_concurrent();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
